uart_send_arb: RTL
==================

// Module: uart_send_arb
// PURPOSE
//  Round-robin arbiter sharing one UART transmit channel (uart_hs send req/ack/data) among
//  NUM_CLIENTS requesters. Each client and the downstream sender use a 4-phase req/ack handshake.
//  Optional per-grant header byte tags which client owns the following bytes; cli_lock holds the
//  grant so a client can send a multi-byte burst without interleaving.
// PARAMETERS
//  NUM_CLIENTS 4      number of requesters, legal 2..8; IDX_W = clog2(NUM_CLIENTS), min 1
//  HDR_EN      1      1: send header byte (HDR_BASE | idx) at start of each new grant; 0: none
//  HDR_BASE    8'hA0  header base; low IDX_W bits must be 0
//  HOLD_MAX    1024   HOLD-state timeout in cycles, legal 1..65535 (16-bit counter)
// PORTS
//  sys_clk     in   1               clock, all logic on rising edge
//  sys_rst     in   1               synchronous reset, active-high
//  cli_req     in   NUM_CLIENTS     per-client send request (4-phase)
//  cli_lock    in   NUM_CLIENTS     per-client keep-grant after current byte
//  cli_data    in   8*NUM_CLIENTS   client i byte at [8i+7:8i], stable while cli_req[i]=1
//  cli_ack     out  NUM_CLIENTS     per-client ack, one-hot or zero
//  tx_req      out  1               to uart_send_req
//  tx_ack      in   1               from uart_send_ack
//  tx_data     out  8               to uart_data_in, stable while tx_req=1
//  grant_idx   out  IDX_W           current/last granted client
//  busy        out  1               1 whenever state != IDLE
// BEHAVIOUR
//  All outputs registered. Reset: tx_req=0, tx_data=0, cli_ack=0, grant_idx=0, busy=0,
//   state=IDLE, last=NUM_CLIENTS-1 (client 0 has first priority), hold counter=0.
//  4-phase rule, both sides: req 0->1, ack 0->1, req 1->0, ack 1->0; next req only after ack=0.
//  IDLE: when |cli_req and tx_ack=0 -> pick first set req scanning last+1, last+2, ... (modulo
//   NUM_CLIENTS); grant_idx<=g; latch cli_data[g] into data reg; -> HDR_REQ if HDR_EN, else DAT_REQ.
//   tx_ack=1 in IDLE (stale, e.g. after reset mid-byte) blocks new grants until it drops.
//  HDR_REQ: tx_req=1, tx_data=HDR_BASE|g; on tx_ack=1 -> HDR_REL.
//  HDR_REL: tx_req=0; on tx_ack=0 -> DAT_REQ.
//  DAT_REQ: tx_req=1, tx_data=latched byte; on tx_ack=1 -> DAT_REL.
//  DAT_REL: tx_req=0; on tx_ack=0 -> CLI_ACK.
//  CLI_ACK: cli_ack[g]=1; on cli_req[g]=0 -> cli_ack[g]=0, last<=g, hold counter cleared;
//   cli_lock[g] sampled that cycle: 1 -> HOLD, 0 -> IDLE.
//  HOLD: cli_lock[g]=0 -> IDLE (lock drop wins even if cli_req[g]=1 same cycle);
//   else cli_req[g]=1 -> latch cli_data[g], -> DAT_REQ (no header);
//   else counter+1; counter reaches HOLD_MAX-1 -> IDLE. Other clients wait during HOLD.
//  Latency (HDR_EN=0): cli_req edge in IDLE -> tx_req=1 on 1st following edge; tx_ack fall ->
//   cli_ack=1 on 1st following edge. HDR_EN adds one full downstream handshake per grant.
//  Unselected clients' cli_ack stay 0; their reqs are held pending, never dropped.
//  cli_req[g] dropping before cli_ack (violation): byte still sent; CLI_ACK completes at once.
//  Reset mid-operation: outputs to reset values on that edge; no byte/ack replayed.
//  grant_idx holds last grant value in IDLE.
// TESTING
//  1 HDR_EN=0, cli_req=4'b0001, cli_data0=8'h55 -> tx_req next cycle, tx_data=8'h55;
//    after tx_ack 1->0, cli_ack=4'b0001; release -> IDLE, busy=0.
//  2 HDR_EN=1, reqs 4'b1111 held (data i=8'h10+i), lock=0 -> tx byte sequence
//    A0,10,A1,11,A2,12,A3,13 then A0,10 again (round robin, each byte headed).
//  3 HDR_EN=1, client 2 lock=1, three bytes 8'h31,32,33, client 0 req pending -> A2,31,32,33,
//    then lock=0 -> A0,<c0 byte>; no client-0 byte interleaved.
//  4 HOLD_MAX=16, client 1 lock=1, no further req -> IDLE exactly 16 cycles after entering HOLD;
//    pending client 3 then granted with header A3.
//  5 Assert sys_rst during DAT_REQ with tx_ack held 1 by bench -> tx_req=0, cli_ack=0 next edge;
//    no new tx_req until bench drops tx_ack; then client 0 served first.

Source files
------------

// File: rtl/uart_send_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_send_arb
// Brief    : Round-robin arbiter sharing one 4-phase UART send channel among
//            NUM_CLIENTS requesters. It can emit a header byte per grant and
//            lets a client hold the grant across a multi-byte burst.
// Revision : 1.0 - initial release
// ============================================================================
module uart_send_arb #(
  parameter int         NUM_CLIENTS = 4,
  parameter bit         HDR_EN      = 1'b1,
  parameter logic [7:0] HDR_BASE    = 8'hA0,
  parameter int         HOLD_MAX    = 1024,
  localparam int        IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_CLIENTS-1:0]   cli_req,
  input  logic [NUM_CLIENTS-1:0]   cli_lock,
  input  logic [8*NUM_CLIENTS-1:0] cli_data,
  output logic [NUM_CLIENTS-1:0]   cli_ack,
  output logic                     tx_req,
  input  logic                     tx_ack,
  output logic [7:0]               tx_data,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy
);

  localparam logic [2:0]  c_IDLE      = 3'd0;
  localparam logic [2:0]  c_HDR_REQ   = 3'd1;
  localparam logic [2:0]  c_HDR_REL   = 3'd2;
  localparam logic [2:0]  c_DAT_REQ   = 3'd3;
  localparam logic [2:0]  c_DAT_REL   = 3'd4;
  localparam logic [2:0]  c_CLI_ACK   = 3'd5;
  localparam logic [2:0]  c_HOLD      = 3'd6;
  localparam logic [15:0] c_HOLD_LAST = 16'(HOLD_MAX - 1);

  logic [2:0]             state_q,    state_d;
  logic [IDX_W-1:0]       last_q,     last_d;
  logic [IDX_W-1:0]       grant_q,    grant_d;
  logic [7:0]             data_q,     data_d;
  logic [15:0]            hold_cnt_q, hold_cnt_d;
  logic                   tx_req_q,   tx_req_d;
  logic [7:0]             tx_data_q,  tx_data_d;
  logic [NUM_CLIENTS-1:0] cli_ack_q,  cli_ack_d;
  logic                   busy_q,     busy_d;

  logic [7:0]             cli_byte [NUM_CLIENTS];
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;

  // Split the flat client data bus into one byte per client
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign cli_byte[i] = cli_data[8*i +: 8];
  end

  // Round-robin pick: first active request scanning upward from the last winner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_CLIENTS);
      if (!pick_found && cli_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register plus registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= c_IDLE;
      last_q     <= IDX_W'(NUM_CLIENTS - 1);
      grant_q    <= '0;
      data_q     <= '0;
      hold_cnt_q <= '0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      cli_ack_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      hold_cnt_q <= hold_cnt_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      cli_ack_q  <= cli_ack_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: both handshakes advance one phase at a time
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    data_d     = data_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      c_IDLE: begin
        // A stale tx_ack (e.g. reset mid-byte) must clear before a new grant
        if (pick_found && !tx_ack) begin
          grant_d = pick_idx;
          data_d  = cli_byte[pick_idx];
          state_d = HDR_EN ? c_HDR_REQ : c_DAT_REQ;
        end
      end
      c_HDR_REQ: if (tx_ack)  state_d = c_HDR_REL;
      c_HDR_REL: if (!tx_ack) state_d = c_DAT_REQ;
      c_DAT_REQ: if (tx_ack)  state_d = c_DAT_REL;
      c_DAT_REL: if (!tx_ack) state_d = c_CLI_ACK;
      c_CLI_ACK: begin
        if (!cli_req[grant_q]) begin
          last_d     = grant_q;
          hold_cnt_d = '0;
          state_d    = cli_lock[grant_q] ? c_HOLD : c_IDLE;
        end
      end
      c_HOLD: begin
        // Lock release takes priority over a simultaneous new request
        if (!cli_lock[grant_q]) begin
          state_d = c_IDLE;
        end else if (cli_req[grant_q]) begin
          data_d  = cli_byte[grant_q];
          state_d = c_DAT_REQ;
        end else if (hold_cnt_q == c_HOLD_LAST) begin
          state_d = c_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    tx_req_d  = (state_d == c_HDR_REQ) || (state_d == c_DAT_REQ);
    tx_data_d = tx_data_q;
    if (state_d == c_HDR_REQ) begin
      tx_data_d = HDR_BASE | 8'(grant_d);
    end else if (state_d == c_DAT_REQ) begin
      tx_data_d = data_d;
    end
    cli_ack_d = '0;
    if (state_d == c_CLI_ACK) begin
      cli_ack_d[grant_d] = 1'b1;
    end
    busy_d = (state_d != c_IDLE);
  end

  assign cli_ack   = cli_ack_q;
  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
